// File: rtl/stream_loader_if.sv
// Beat-stream input and memory write buses of the stream loader.
// The loader attaches to the slave modport and the stream source/memories to the master modport.
interface stream_loader_if #(
    parameter int IN_WIDTH   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) ();
    // A beat transfers on a rising clock edge where input_vld && input_rdy. input_vld may
    // rise regardless of input_rdy, and input_data must hold steady while input_vld is high
    // and the beat has not yet been accepted. Each *_wen is a one-cycle write strobe, with
    // its address and word valid in that same cycle.
    logic [IN_WIDTH-1:0]   input_data;
    logic                  input_vld;
    logic                  input_rdy;
    logic                  instr_wen;
    logic [ADDR_WIDTH-1:0] instr_wadr;
    logic [DATA_WIDTH-1:0] instr_wdata;
    logic                  data_wen;
    logic [ADDR_WIDTH-1:0] data_wadr;
    logic [DATA_WIDTH-1:0] data_wdata;

    modport slave (
        input  input_data,
        input  input_vld,
        output input_rdy,
        output instr_wen,
        output instr_wadr,
        output instr_wdata,
        output data_wen,
        output data_wadr,
        output data_wdata
    );

    modport master (
        output input_data,
        output input_vld,
        input  input_rdy,
        input  instr_wen,
        input  instr_wadr,
        input  instr_wdata,
        input  data_wen,
        input  data_wadr,
        input  data_wdata
    );
endinterface

// File: rtl/stream_loader.sv
// Parses the 16-bit input stream into config registers, instruction words and per-frame data words.
// Optional LOADER_RELOAD_EN adds a `reload` input that returns the loader to config parsing.
module stream_loader #(
    parameter int IN_WIDTH    = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int NUM_CONFIGS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_loader_if.slave        bus,
    output logic [ADDR_WIDTH-1:0] instr_max_wadr,
    output logic [ADDR_WIDTH-1:0] input_max_wadr,
    output logic [ADDR_WIDTH-1:0] input_wadr_offset,
    output logic [ADDR_WIDTH-1:0] output_max_adr,
    output logic [ADDR_WIDTH-1:0] output_adr_offset,
    output logic                  start,
    input  logic                  done,
    output logic [7:0]            frame_cnt,
`ifdef LOADER_RELOAD_EN
    input  logic                  reload,
`endif
    output logic [1:0]            o_dbg_state
);

    localparam int CFG_IW = (NUM_CONFIGS > 1) ? $clog2(NUM_CONFIGS) : 1;

    typedef enum logic [1:0] {
        ST_CONFIG = 2'd0,
        ST_INSTR  = 2'd1,
        ST_DATA   = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_rdy;
    logic [CFG_IW-1:0]     r_cfg_idx;
    logic [ADDR_WIDTH-1:0] r_cfg [NUM_CONFIGS];
    logic                  r_half;
    logic [IN_WIDTH-1:0]   r_low;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_instr_wen;
    logic [ADDR_WIDTH-1:0] r_instr_wadr;
    logic [DATA_WIDTH-1:0] r_instr_wdata;
    logic                  r_data_wen;
    logic [ADDR_WIDTH-1:0] r_data_wadr;
    logic [DATA_WIDTH-1:0] r_data_wdata;
    logic                  r_start;
    logic [7:0]            r_frame_cnt;

    logic                  w_reload;
    logic                  w_accept;
    logic                  w_cfg_last;
    logic                  w_word_done;
    logic                  w_instr_last;
    logic                  w_data_last;
    logic                  w_done_take;

`ifdef LOADER_RELOAD_EN
    assign w_reload = reload;
`else
    assign w_reload = 1'b0;
`endif

    assign w_accept     = bus.input_vld & r_rdy;
    assign w_cfg_last   = (r_cfg_idx == CFG_IW'(NUM_CONFIGS - 1));
    assign w_word_done  = w_accept & r_half & ((r_state == ST_INSTR) | (r_state == ST_DATA));
    assign w_instr_last = (r_idx == r_cfg[0]);
    assign w_data_last  = (r_idx == r_cfg[1]);
    // A done that lines up with the start pulse belongs to the previous frame and is dropped.
    assign w_done_take  = (r_state == ST_RUN) & done & ~r_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CONFIG;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_rdy   <= (w_next_state != ST_RUN);
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_reload) begin
            w_next_state = ST_CONFIG;
        end else begin
            case (r_state)
                ST_CONFIG: if (w_accept && w_cfg_last)        w_next_state = ST_INSTR;
                ST_INSTR:  if (w_word_done && w_instr_last)   w_next_state = ST_DATA;
                ST_DATA:   if (w_word_done && w_data_last)    w_next_state = ST_RUN;
                ST_RUN:    if (w_done_take)                   w_next_state = ST_DATA;
                default:                                      w_next_state = ST_CONFIG;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_idx     <= '0;
            for (int i = 0; i < NUM_CONFIGS; i++) r_cfg[i] <= '0;
            r_half        <= 1'b0;
            r_low         <= '0;
            r_idx         <= '0;
            r_instr_wen   <= 1'b0;
            r_instr_wadr  <= '0;
            r_instr_wdata <= '0;
            r_data_wen    <= 1'b0;
            r_data_wadr   <= '0;
            r_data_wdata  <= '0;
            r_start       <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_instr_wen <= 1'b0;
            r_data_wen  <= 1'b0;
            r_start     <= 1'b0;
            if (w_reload) begin
                r_cfg_idx <= '0;
                r_half    <= 1'b0;
                r_low     <= '0;
                r_idx     <= '0;
            end else begin
                // Only the final write of a frame is seen while already in RUN.
                r_start <= r_data_wen & (r_state == ST_RUN);
                if (w_done_take) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                    r_idx       <= '0;
                    r_half      <= 1'b0;
                end
                if (w_accept) begin
                    case (r_state)
                        ST_CONFIG: begin
                            for (int i = 0; i < NUM_CONFIGS; i++) begin
                                if (r_cfg_idx == CFG_IW'(i)) r_cfg[i] <= bus.input_data;
                            end
                            r_cfg_idx <= w_cfg_last ? '0 : r_cfg_idx + CFG_IW'(1);
                        end
                        ST_INSTR: begin
                            r_half <= ~r_half;
                            if (!r_half) begin
                                r_low <= bus.input_data;
                            end else begin
                                r_instr_wen   <= 1'b1;
                                r_instr_wadr  <= r_idx;
                                r_instr_wdata <= {bus.input_data, r_low};
                                r_idx         <= w_instr_last ? '0 : r_idx + ADDR_WIDTH'(1);
                            end
                        end
                        ST_DATA: begin
                            r_half <= ~r_half;
                            if (!r_half) begin
                                r_low <= bus.input_data;
                            end else begin
                                r_data_wen   <= 1'b1;
                                r_data_wadr  <= r_cfg[2] + r_idx;
                                r_data_wdata <= {bus.input_data, r_low};
                                r_idx        <= w_data_last ? '0 : r_idx + ADDR_WIDTH'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.input_rdy   = r_rdy;
    assign bus.instr_wen   = r_instr_wen;
    assign bus.instr_wadr  = r_instr_wadr;
    assign bus.instr_wdata = r_instr_wdata;
    assign bus.data_wen    = r_data_wen;
    assign bus.data_wadr   = r_data_wadr;
    assign bus.data_wdata  = r_data_wdata;

    assign instr_max_wadr    = r_cfg[0];
    assign input_max_wadr    = r_cfg[1];
    assign input_wadr_offset = r_cfg[2];
    assign output_max_adr    = r_cfg[3];
    assign output_adr_offset = r_cfg[4];

    assign start       = r_start;
    assign frame_cnt   = r_frame_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stream_loader.sv
// Self-checking bench for stream_loader: random beats and gaps against a queue-based reference model.
// Build with LOADER_RELOAD_EN defined to also exercise the reload input.
module tb_stream_loader;

    localparam int IW = 16;
    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          done = 1'b0;
    logic [AW-1:0] instr_max_wadr, input_max_wadr, input_wadr_offset;
    logic [AW-1:0] output_max_adr, output_adr_offset;
    logic          start;
    logic [7:0]    frame_cnt;
    logic [1:0]    dbg_state;
`ifdef LOADER_RELOAD_EN
    logic          reload = 1'b0;
`endif

    stream_loader_if #(.IN_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    stream_loader #(.IN_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CONFIGS(5)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .instr_max_wadr    (instr_max_wadr),
        .input_max_wadr    (input_max_wadr),
        .input_wadr_offset (input_wadr_offset),
        .output_max_adr    (output_max_adr),
        .output_adr_offset (output_adr_offset),
        .start             (start),
        .done              (done),
        .frame_cnt         (frame_cnt),
`ifdef LOADER_RELOAD_EN
        .reload            (reload),
`endif
        .o_dbg_state       (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    logic [15:0] cfg_m [5];
    logic [47:0] exp_q[$];
    int          exp_frame = 0;

    // ---------------- monitor ----------------
    logic [47:0] act_instr_q[$];
    logic [47:0] act_data_q[$];
    int          data_cyc_q[$];
    int          start_cyc_q[$];

    always @(negedge clk) begin
        if (bus.instr_wen === 1'b1) act_instr_q.push_back({bus.instr_wadr, bus.instr_wdata});
        if (bus.data_wen === 1'b1) begin
            act_data_q.push_back({bus.data_wadr, bus.data_wdata});
            data_cyc_q.push_back(cyc);
        end
        if (start === 1'b1) start_cyc_q.push_back(cyc);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send_beat(input logic [15:0] b, input bit gaps);
        int guard;
        if (gaps && $urandom_range(0, 1) == 1) begin
            bus.input_vld = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        bus.input_data = b;
        bus.input_vld  = 1'b1;
        guard = 0;
        while (bus.input_rdy !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: input_rdy stayed %b for beat %h, required 1", bus.input_rdy, b);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        send_beat(w[15:0], gaps);
        send_beat(w[31:16], gaps);
    endtask

    task automatic send_config(input bit gaps);
        for (int i = 0; i < 5; i++) send_beat(cfg_m[i], gaps);
    endtask

    // Model: instruction i lands at address i; builds exp_q and drives the words.
    task automatic send_instr(input bit gaps);
        logic [31:0] w;
        exp_q.delete();
        act_instr_q.delete();
        for (int i = 0; i <= int'(cfg_m[0]); i++) begin
            w = $urandom;
            exp_q.push_back({16'(i), w});
        end
        for (int i = 0; i < exp_q.size(); i++) send_word(exp_q[i][31:0], gaps);
        bus.input_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.input_vld = 1'b0;
        bus.input_data = '0;
        done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_frame = 0;
        @(negedge clk);
    endtask

    task automatic compare_instr();
        checks++;
        if (act_instr_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL instr_count: got %0d writes, required %0d", act_instr_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= act_instr_q.size() || act_instr_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL instr_write[%0d]: got %h, required %h", i,
                         (i < act_instr_q.size()) ? act_instr_q[i] : 48'hx, exp_q[i]);
            end
        end
    endtask

    task automatic check_cfg();
        logic [15:0] got [5];
        got[0] = instr_max_wadr; got[1] = input_max_wadr; got[2] = input_wadr_offset;
        got[3] = output_max_adr; got[4] = output_adr_offset;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== cfg_m[i]) begin
                errors++;
                $display("FAIL cfg_reg[%0d]: got %h, required %h", i, got[i], cfg_m[i]);
            end
        end
    endtask

    // One data frame: model address = (offset + i) mod 2^16; junk held on the bus during RUN.
    task automatic run_frame(input bit gaps, input bit coincide);
        int n;
        int n_acc;
        logic [31:0] w;
        n = int'(cfg_m[1]) + 1;
        exp_q.delete(); act_data_q.delete(); data_cyc_q.delete(); start_cyc_q.delete();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_q.push_back({16'((int'(cfg_m[2]) + i) % 65536), w});
        end
        for (int i = 0; i < n; i++) send_word(exp_q[i][31:0], gaps);
        bus.input_data = 16'hBAD0;
        bus.input_vld  = 1'b1;
        checks++;
        if (bus.input_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rdy_enter_run: got %b, required 0", bus.input_rdy);
        end
        if (coincide) begin
            @(negedge clk);
            checks++;
            if (start !== 1'b1) begin
                errors++;
                $display("FAIL start_pulse: got %b, required 1", start);
            end
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            checks++;
            if (bus.input_rdy !== 1'b0 || frame_cnt !== 8'(exp_frame)) begin
                errors++;
                $display("FAIL done_with_start: rdy %b cnt %0d, required rdy 0 cnt %0d",
                         bus.input_rdy, frame_cnt, exp_frame);
            end
        end else begin
            repeat (2) @(negedge clk);
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
        checks++;
        if (act_data_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL data_count: got %0d writes, required %0d", act_data_q.size(), exp_q.size());
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (i >= act_data_q.size() || act_data_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL data_write[%0d]: got %h, required %h", i,
                         (i < act_data_q.size()) ? act_data_q[i] : 48'hx, exp_q[i]);
            end
        end
        checks++;
        if (start_cyc_q.size() !== 1) begin
            errors++;
            $display("FAIL start_count: got %0d pulses, required 1", start_cyc_q.size());
        end else begin
            checks++;
            if (data_cyc_q.size() == 0 || start_cyc_q[0] !== data_cyc_q[data_cyc_q.size()-1] + 1) begin
                errors++;
                $display("FAIL start_timing: start cycle %0d, required one after last write", start_cyc_q[0]);
            end
        end
        if (!gaps) begin
            for (int i = 1; i < data_cyc_q.size(); i++) begin
                checks++;
                if (data_cyc_q[i] - data_cyc_q[i-1] !== 2) begin
                    errors++;
                    $display("FAIL throughput[%0d]: spacing %0d, required 2", i, data_cyc_q[i] - data_cyc_q[i-1]);
                end
            end
        end
        n_acc = act_data_q.size();
        checks++;
        if (bus.input_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rdy_in_run: got %b, required 0", bus.input_rdy);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        bus.input_vld = 1'b0;
        exp_frame = (exp_frame + 1) % 256;
        checks++;
        if (bus.input_rdy !== 1'b1 || frame_cnt !== 8'(exp_frame)) begin
            errors++;
            $display("FAIL done_accept: rdy %b cnt %0d, required rdy 1 cnt %0d", bus.input_rdy, frame_cnt, exp_frame);
        end
        checks++;
        if (act_data_q.size() !== n_acc) begin
            errors++;
            $display("FAIL no_extra_beat: got %0d writes, required %0d", act_data_q.size(), n_acc);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.input_vld = 1'b0;
        bus.input_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.input_rdy !== 1'b0 || bus.instr_wen !== 1'b0 || bus.data_wen !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rdy %b iwen %b dwen %b start %b, required all 0",
                     bus.input_rdy, bus.instr_wen, bus.data_wen, start);
        end
        checks++;
        if (bus.instr_wadr !== '0 || bus.instr_wdata !== '0 || bus.data_wadr !== '0 ||
            bus.data_wdata !== '0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_bus: iadr %h idat %h dadr %h ddat %h cnt %0d, required all 0",
                     bus.instr_wadr, bus.instr_wdata, bus.data_wadr, bus.data_wdata, frame_cnt);
        end
        for (int i = 0; i < 5; i++) cfg_m[i] = '0;
        check_cfg();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.input_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rdy_after_reset: got %b, required 1", bus.input_rdy);
        end
    endtask

    task automatic test_config_instr();
        logic [31:0] words [2];
        cfg_m[0] = 16'h0001; cfg_m[1] = 16'h0003; cfg_m[2] = 16'h07D0;
        cfg_m[3] = 16'h0003; cfg_m[4] = 16'h07E8;
        send_config(1'b0);
        check_cfg();
        words[0] = 32'h12345678;
        words[1] = 32'hDEADBEEF;
        exp_q.delete();
        act_instr_q.delete();
        for (int i = 0; i < 2; i++) exp_q.push_back({16'(i), words[i]});
        for (int i = 0; i < 2; i++) send_word(words[i], 1'b0);
        bus.input_vld = 1'b0;
        repeat (2) @(negedge clk);
        compare_instr();
    endtask

    task automatic test_data_frame();
        run_frame(1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) run_frame(f[0], f == 2);
    endtask

    task automatic test_instr_gaps();
        do_reset();
        cfg_m[0] = 16'($urandom_range(1, 6));
        cfg_m[1] = 16'h0000;
        cfg_m[2] = 16'($urandom);
        cfg_m[3] = 16'($urandom);
        cfg_m[4] = 16'($urandom);
        send_config(1'b1);
        check_cfg();
        send_instr(1'b1);
        compare_instr();
        run_frame(1'b1, 1'b0);
        run_frame(1'b0, 1'b0);
    endtask

    task automatic test_offset_wrap();
        do_reset();
        cfg_m[0] = 16'h0000; cfg_m[1] = 16'h0003; cfg_m[2] = 16'hFFFE;
        cfg_m[3] = 16'($urandom); cfg_m[4] = 16'($urandom);
        send_config(1'b0);
        send_instr(1'b0);
        compare_instr();
        run_frame(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [15:0] b;
        do_reset();
        cfg_m[0] = 16'h0000; cfg_m[1] = 16'h0001; cfg_m[2] = 16'($urandom);
        cfg_m[3] = 16'($urandom); cfg_m[4] = 16'($urandom);
        send_config(1'b0);
        send_instr(1'b0);
        run_frame(1'b0, 1'b0);
        send_beat(16'hA5A5, 1'b0);
        bus.input_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.input_rdy !== 1'b0 || frame_cnt !== 8'd0 || start !== 1'b0 ||
            bus.data_wen !== 1'b0 || bus.data_wadr !== '0 || bus.data_wdata !== '0) begin
            errors++;
            $display("FAIL reset_async: rdy %b cnt %0d start %b dwen %b dadr %h ddat %h, required all 0",
                     bus.input_rdy, frame_cnt, start, bus.data_wen, bus.data_wadr, bus.data_wdata);
        end
        for (int i = 0; i < 5; i++) cfg_m[i] = '0;
        check_cfg();
        exp_frame = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b = 16'($urandom_range(1, 65535));
        send_beat(b, 1'b0);
        bus.input_vld = 1'b0;
        cfg_m[0] = b;
        check_cfg();
    endtask

`ifdef LOADER_RELOAD_EN
    task automatic test_reload();
        logic [15:0] b;
        logic [7:0]  cnt_before;
        do_reset();
        cfg_m[0] = 16'h0000; cfg_m[1] = 16'h0001; cfg_m[2] = 16'($urandom);
        cfg_m[3] = 16'($urandom); cfg_m[4] = 16'($urandom);
        send_config(1'b0);
        send_instr(1'b0);
        run_frame(1'b0, 1'b0);
        cnt_before = 8'(exp_frame);
        start_cyc_q.delete();
        for (int i = 0; i <= int'(cfg_m[1]); i++) send_word($urandom, 1'b0);
        bus.input_vld = 1'b0;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        checks++;
        if (bus.input_rdy !== 1'b1 || start !== 1'b0 || frame_cnt !== cnt_before) begin
            errors++;
            $display("FAIL reload_run: rdy %b start %b cnt %0d, required rdy 1 start 0 cnt %0d",
                     bus.input_rdy, start, frame_cnt, cnt_before);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (start_cyc_q.size() !== 0) begin
            errors++;
            $display("FAIL reload_no_start: got %0d pulses, required 0", start_cyc_q.size());
        end
        b = 16'($urandom);
        send_beat(b, 1'b0);
        bus.input_vld = 1'b0;
        cfg_m[0] = b;
        check_cfg();
    endtask
`endif

    initial begin
        bus.input_vld = 1'b0;
        bus.input_data = '0;
        test_reset();
        test_config_instr();
        test_data_frame();
        test_back_to_back();
        test_instr_gaps();
        test_offset_wrap();
        test_reset_mid();
`ifdef LOADER_RELOAD_EN
        test_reload();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_loader.md
# stream_loader

Front-end controller for the accelerator's single 16-bit ready/valid input port. It parses the incoming beat stream into five configuration registers, then 32-bit instruction-memory writes, then 32-bit data-memory writes. After each data frame it pulses `start` to the compute core and stalls the input until the core reports `done`. Configuration and instructions persist across frames; every later frame reloads only data.

## Interface
- `IN_WIDTH`, 16, input beat width
- `DATA_WIDTH`, 32, instruction/data word width; must equal 2*IN_WIDTH
- `ADDR_WIDTH`, 16, memory address and config register width
- `NUM_CONFIGS`, 5, config words at stream head

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `input_data`  in  IN_WIDTH  stream beat
- `input_vld`  in  1  beat valid
- `input_rdy`  out  1  beat accepted on a clock edge when `input_vld && input_rdy`
- `instr_wen`  out  1  instruction memory write strobe
- `instr_wadr`  out  ADDR_WIDTH  instruction write address
- `instr_wdata`  out  DATA_WIDTH  instruction write word
- `data_wen`  out  1  data memory write strobe
- `data_wadr`  out  ADDR_WIDTH  data write address
- `data_wdata`  out  DATA_WIDTH  data write word
- `instr_max_wadr`, `input_max_wadr`, `input_wadr_offset`, `output_max_adr`, `output_adr_offset`  out  ADDR_WIDTH each  config registers 0..4
- `start`  out  1  one-cycle core start pulse
- `done`  in  1  core frame-complete pulse
- `frame_cnt`  out  8  completed frames, wraps 255->0

## Operation
- States: CONFIG -> INSTR -> DATA -> RUN -> DATA -> RUN ...
- CONFIG: each accepted beat goes to config register `cfg_idx` (0..4), in port order. The beat with `cfg_idx == NUM_CONFIGS-1` moves the FSM to INSTR.
- INSTR and DATA: beats are paired. The first beat is bits [15:0] and the second is bits [31:16]. One half-select bit toggles on every accepted beat. The word is written when its high half is accepted.
- INSTR: addresses run 0..`instr_max_wadr`. The write at `instr_max_wadr` moves the FSM to DATA with the word index cleared.
- DATA: address = `input_wadr_offset + idx`, computed mod 2^ADDR_WIDTH (offset wrap allowed). `idx` runs 0..`input_max_wadr`. The write at `input_max_wadr` moves the FSM to RUN.
- RUN: no beats accepted. `done` sampled high moves the FSM to DATA, clears `idx` and the half-select bit, and increments `frame_cnt`. `done` outside RUN is ignored.
- Max values of 0 are legal: one instruction word (2 beats) and one data word (2 beats).
- Reset mid-operation clears all state, including any held half word. The config registers also reset, so the stream must restart with config.

## Timing
- Reset values: `input_rdy`=0, all `*_wen`=0, addresses/wdata=0, config regs=0, `start`=0, `frame_cnt`=0, FSM=CONFIG, indices=0.
- `input_rdy` is registered, equal to (next state != RUN). After `rst_n` rises it is 1 from the first clock edge onward.
- The accepting edge of the last data beat enters RUN and drops `input_rdy` at that same edge, so no extra beat is accepted.
- Write strobe latency: `*_wen`, address and wdata are registered. They are high for exactly one cycle, following the edge that accepted the high half.
- `start` rises one edge after the final `data_wen` (it is high the cycle after the write cycle) and lasts one cycle.
- `done` accepted at edge k gives `input_rdy`=1 and the new `frame_cnt` from edge k. `done` coincident with `start` is ignored.
- Throughput: one beat per cycle, so one word write every 2 cycles with no bubbles while `input_vld` is held high.

## Configuration
- `LOADER_RELOAD_EN`
  - Defined: adds input port `reload` (1 bit). A `reload` pulse sampled high in any state has priority over everything else. It returns the FSM to CONFIG, clears indices and the half-select bit, drops pending strobes, and sets `input_rdy`=1. `frame_cnt` and config registers hold until overwritten.
  - Undefined: no port. CONFIG is re-entered only through `rst_n`.

## Test plan
- Config then 2 instructions: beats 0x0001, 0x0003, 0x07D0, 0x0003, 0x07E8, then 0x5678, 0x1234, 0xBEEF, 0xDEAD -> config regs read 1/3/0x7D0/3/0x7E8; `instr_wen` pulses with adr 0 data 0x12345678 and adr 1 data 0xDEADBEEF.
- 4 data words, then `done` -> `data_wen` at 0x7D0..0x7D3; `start` pulses once, one cycle after the 0x7D3 write; `input_rdy`=0 until `done`, then 1 and `frame_cnt`=1.
- `input_vld` toggling every other cycle during INSTR -> identical writes at identical addresses; no write on non-accepted cycles.
- Offset 0xFFFE with `input_max_wadr`=3 -> data addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `rst_n` low after one low half in DATA -> all outputs at reset values immediately; after release the next beat is stored as config register 0.
- With `LOADER_RELOAD_EN`, `reload` pulse in RUN -> `input_rdy`=1 the next cycle, FSM in CONFIG, no `start`, `frame_cnt` unchanged.
